// File: rtl/rv_fetch_queue_pkg.sv
// Shared fetch-stage constants, the prefetch queue entry layout and small helpers.
package rv_fetch_queue_pkg;

    localparam logic [31:0] RV_NOP          = 32'h0000_0013;
    localparam logic [31:0] RV_RESET_VECTOR = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] ir;
    } fetch_entry_t;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/rv_fetch_queue_if.sv
// Fetch stage bus: instruction-memory read port, decode-side output and redirect input.
interface rv_fetch_queue_if;

    logic [31:0] im_addr_o;
    logic        im_rd_o;
    logic [31:0] im_data_i;
    logic        im_valid_i;
    logic        f_stall_i;
    logic        f_kill_i;
    logic [31:0] f_ir_o;
    logic [31:0] f_pc_o;
    logic [31:0] f_pc_plus_4_o;
    logic        f_valid_o;
    logic [31:0] x_pc_bra_i;
    logic        x_bra_i;

    modport master (
        output im_addr_o, im_rd_o, f_ir_o, f_pc_o, f_pc_plus_4_o, f_valid_o,
        input  im_data_i, im_valid_i, f_stall_i, f_kill_i, x_pc_bra_i, x_bra_i
    );

    modport slave (
        input  im_addr_o, im_rd_o, f_ir_o, f_pc_o, f_pc_plus_4_o, f_valid_o,
        output im_data_i, im_valid_i, f_stall_i, f_kill_i, x_pc_bra_i, x_bra_i
    );

endinterface

// File: rtl/rv_fetch_queue_fifo.sv
// Synchronous FIFO of {pc, ir} entries; flush beats push and pop.
module rv_fetch_queue_fifo
    import rv_fetch_queue_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                         clk_i,
    input  logic                         rst_n_i,
    input  logic                         i_push,
    input  fetch_entry_t                 i_wdata,
    input  logic                         i_pop,
    input  logic                         i_flush,
    output fetch_entry_t                 o_rdata,
    output logic                         o_full,
    output logic                         o_empty,
    output logic [$clog2(DEPTH+1)-1:0]   o_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    fetch_entry_t  r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [CW-1:0] r_count;
    logic          w_push;
    logic          w_pop;

    assign o_empty = (r_count == '0);
    assign o_full  = (r_count == CW'(DEPTH));
    assign o_count = r_count;
    assign o_rdata = r_mem[r_rptr];

    // A full queue still accepts a push when the head leaves in the same cycle.
    assign w_pop  = i_pop && !o_empty;
    assign w_push = i_push && (!o_full || w_pop);

    always_ff @(posedge clk_i) begin
        if (!rst_n_i || i_flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + AW'(1);
            if (w_pop)  r_rptr <= r_rptr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_push && !i_flush) r_mem[r_wptr] <= i_wdata;
    end

endmodule

// File: rtl/rv_fetch_queue.sv
// Fetch stage: in-order pipelined instruction reads feeding a prefetch queue,
// registered decode outputs, and redirect handling that discards stale responses.
module rv_fetch_queue
    import rv_fetch_queue_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = RV_RESET_VECTOR,
    parameter int          QUEUE_DEPTH  = 2
) (
    input logic              clk_i,
    input logic              rst_n_i,
    rv_fetch_queue_if.master bus
);

    localparam int CW = $clog2(QUEUE_DEPTH + 1);
    localparam int IW = CW + 1;

    logic [31:0]   r_fetch_pc;
    logic [31:0]   r_resp_pc;
    logic [CW-1:0] r_outstanding;
    logic [CW-1:0] r_discard;
    logic          r_run;

    logic          w_issue;
    logic          w_push;
    logic          w_pop;
    logic          w_full;
    logic          w_empty;
    logic [CW-1:0] w_count;
    logic [IW-1:0] w_inflight;
    fetch_entry_t  w_head;
    fetch_entry_t  w_wdata;

    // Reads in flight plus buffered entries never exceed the queue size, so every response has a slot.
    assign w_inflight = {1'b0, r_outstanding} + {1'b0, w_count};
    assign w_issue    = rst_n_i && r_run && !bus.x_bra_i && (w_inflight < IW'(QUEUE_DEPTH));
    assign w_push     = bus.im_valid_i && (r_discard == '0);
    assign w_pop      = !bus.x_bra_i && !bus.f_stall_i && !w_empty;
    assign w_wdata    = '{pc: r_resp_pc, ir: bus.im_data_i};

    assign bus.im_rd_o   = w_issue;
    assign bus.im_addr_o = r_fetch_pc;

    rv_fetch_queue_fifo #(
        .DEPTH (QUEUE_DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .i_push  (w_push),
        .i_wdata (w_wdata),
        .i_pop   (w_pop),
        .i_flush (bus.x_bra_i),
        .o_rdata (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            r_run         <= 1'b0;
            r_fetch_pc    <= RESET_VECTOR;
            r_resp_pc     <= RESET_VECTOR;
            r_outstanding <= '0;
            r_discard     <= '0;
        end else begin
            r_run <= 1'b1;
            if (bus.x_bra_i) begin
                r_fetch_pc    <= word_align(bus.x_pc_bra_i);
                r_resp_pc     <= word_align(bus.x_pc_bra_i);
                r_outstanding <= r_outstanding - CW'(bus.im_valid_i);
                r_discard     <= r_outstanding - CW'(bus.im_valid_i);
            end else begin
                if (w_issue) r_fetch_pc <= r_fetch_pc + 32'd4;
                if (w_push)  r_resp_pc  <= r_resp_pc + 32'd4;
                r_outstanding <= r_outstanding + CW'(w_issue) - CW'(bus.im_valid_i);
                if (bus.im_valid_i && (r_discard != '0)) r_discard <= r_discard - CW'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            bus.f_valid_o     <= 1'b0;
            bus.f_ir_o        <= RV_NOP;
            bus.f_pc_o        <= RESET_VECTOR;
            bus.f_pc_plus_4_o <= RESET_VECTOR + 32'd4;
        end else if (bus.x_bra_i) begin
            bus.f_valid_o <= 1'b0;
        end else if (!bus.f_stall_i) begin
            if (w_pop) begin
                bus.f_ir_o        <= w_head.ir;
                bus.f_pc_o        <= w_head.pc;
                bus.f_pc_plus_4_o <= w_head.pc + 32'd4;
                bus.f_valid_o     <= !bus.f_kill_i;
            end else begin
                bus.f_valid_o <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_n_i && !bus.x_bra_i) assert (!(w_push && w_full && !w_pop));
    end

endmodule

// File: tb/tb_rv_fetch_queue.sv
// Bench for rv_fetch_queue: a latency-configurable memory plus a queue-level reference
// of which instructions decode must see, checked every cycle.
module tb_rv_fetch_queue;

    localparam int          QD  = 2;
    localparam logic [31:0] RV  = 32'h0000_0000;
    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef struct {
        logic [31:0] addr;
        int unsigned epoch;
        int unsigned ready;
    } req_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] ir;
    } ent_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    rv_fetch_queue_if bus ();

    rv_fetch_queue #(
        .RESET_VECTOR (RV),
        .QUEUE_DEPTH  (QD)
    ) dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .bus     (bus)
    );

    req_t        pend[$];
    ent_t        q[$];
    int unsigned cyc = 0;
    int unsigned epoch = 0;
    int unsigned last_ready = 0;
    int unsigned lat_min = 1;
    int unsigned lat_max = 1;
    logic [31:0] m_fetch = RV;
    logic [31:0] m_pc = RV;
    logic [31:0] m_ir = NOP;
    logic        m_valid = 1'b0;
    logic        m_run = 1'b0;
    int          n_checks = 0;
    int          n_pass = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1357_0000;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock cycle, entered and left at the falling edge.
    task automatic cycle(input logic stall, input logic kill, input logic bra, input logic [31:0] tgt);
        logic        resp_now;
        logic        exp_rd;
        logic        rd_seen;
        logic [31:0] addr_seen;
        req_t        rsp;
        req_t        r;
        ent_t        e;
        int unsigned rdy;

        bus.f_stall_i  = stall;
        bus.f_kill_i   = kill;
        bus.x_bra_i    = bra;
        bus.x_pc_bra_i = tgt;
        resp_now       = rst_n && (pend.size() > 0) && (pend[0].ready <= cyc);
        bus.im_valid_i = resp_now;
        bus.im_data_i  = resp_now ? mem_word(pend[0].addr) : $urandom();
        #1;
        exp_rd = rst_n && m_run && !bra && ((pend.size() + q.size()) < QD);
        chk("im_rd", {31'b0, bus.im_rd_o}, {31'b0, exp_rd});
        if (exp_rd) chk("im_addr", bus.im_addr_o, m_fetch);
        rd_seen   = bus.im_rd_o;
        addr_seen = bus.im_addr_o;

        @(posedge clk);
        if (!rst_n) begin
            pend.delete();
            q.delete();
            m_fetch    = RV;
            m_pc       = RV;
            m_ir       = NOP;
            m_valid    = 1'b0;
            m_run      = 1'b0;
            last_ready = cyc;
        end else begin
            m_run = 1'b1;
            if (resp_now) rsp = pend.pop_front();
            if (rd_seen) begin
                rdy = cyc + $urandom_range(lat_max, lat_min);
                if (rdy <= last_ready) rdy = last_ready + 1;
                last_ready = rdy;
                r.addr  = addr_seen;
                r.epoch = epoch;
                r.ready = rdy;
                pend.push_back(r);
            end
            if (bra) begin
                q.delete();
                epoch++;
                m_valid = 1'b0;
                m_fetch = tgt & 32'hFFFF_FFFC;
            end else begin
                if (!stall) begin
                    if (q.size() > 0) begin
                        e       = q.pop_front();
                        m_pc    = e.pc;
                        m_ir    = e.ir;
                        m_valid = !kill;
                    end else begin
                        m_valid = 1'b0;
                    end
                end
                if (resp_now && (rsp.epoch == epoch)) begin
                    e.pc = rsp.addr;
                    e.ir = mem_word(rsp.addr);
                    q.push_back(e);
                end
                if (rd_seen) m_fetch = m_fetch + 32'd4;
            end
        end
        cyc++;

        #1;
        chk("f_valid", {31'b0, bus.f_valid_o}, {31'b0, m_valid});
        chk("f_pc", bus.f_pc_o, m_pc);
        chk("f_ir", bus.f_ir_o, m_ir);
        chk("f_pc_plus_4", bus.f_pc_plus_4_o, m_pc + 32'd4);
        @(negedge clk);
    endtask

    initial begin
        bus.f_stall_i  = 1'b0;
        bus.f_kill_i   = 1'b0;
        bus.x_bra_i    = 1'b0;
        bus.x_pc_bra_i = '0;
        bus.im_valid_i = 1'b0;
        bus.im_data_i  = '0;
        @(negedge clk);

        // Reset state, then sequential fetch with 1-cycle memory.
        repeat (3) cycle(1'b0, 1'b0, 1'b0, 32'h0);
        rst_n = 1'b1;
        repeat (30) cycle(1'b0, 1'b0, 1'b0, 32'h0);

        // Decode stall mid-stream, then release.
        repeat (5) cycle(1'b1, 1'b0, 1'b0, 32'h0);
        repeat (10) cycle(1'b0, 1'b0, 1'b0, 32'h0);

        // Single killed pop.
        cycle(1'b0, 1'b1, 1'b0, 32'h0);
        repeat (6) cycle(1'b0, 1'b0, 1'b0, 32'h0);

        // Latency 3: issue throttled by queue depth.
        lat_min = 3;
        lat_max = 3;
        repeat (30) cycle(1'b0, 1'b0, 1'b0, 32'h0);

        // Redirect to 0x100 with reads in flight.
        cycle(1'b0, 1'b0, 1'b1, 32'h0000_0100);
        repeat (15) cycle(1'b0, 1'b0, 1'b0, 32'h0);

        // Back-to-back redirects with 1-cycle memory; the second wins.
        lat_min = 1;
        lat_max = 1;
        repeat (6) cycle(1'b0, 1'b0, 1'b0, 32'h0);
        cycle(1'b0, 1'b0, 1'b1, 32'h0000_0200);
        cycle(1'b0, 1'b0, 1'b1, 32'h0000_0300);
        repeat (10) cycle(1'b0, 1'b0, 1'b0, 32'h0);

        // Unaligned target near the top of memory: low bits dropped, fetch PC wraps.
        cycle(1'b0, 1'b0, 1'b1, 32'hFFFF_FFF6);
        repeat (12) cycle(1'b0, 1'b0, 1'b0, 32'h0);

        // Redirect while stalled, then stall into a full queue.
        cycle(1'b1, 1'b0, 1'b1, 32'h0000_0040);
        repeat (6) cycle(1'b1, 1'b0, 1'b0, 32'h0);
        repeat (8) cycle(1'b0, 1'b0, 1'b0, 32'h0);

        // Reset in the middle of traffic.
        lat_max = 3;
        repeat (5) cycle(1'b0, 1'b0, 1'b0, 32'h0);
        rst_n = 1'b0;
        repeat (2) cycle(1'b0, 1'b0, 1'b0, 32'h0);
        rst_n = 1'b1;
        repeat (12) cycle(1'b0, 1'b0, 1'b0, 32'h0);

        // Random mix of latency, stalls, kills and redirects.
        for (int i = 0; i < 1600; i++) begin
            if ((i % 200) == 0) begin
                lat_min = $urandom_range(2, 1);
                lat_max = lat_min + $urandom_range(3, 0);
            end
            cycle($urandom_range(3, 0) == 0, $urandom_range(7, 0) == 0,
                  $urandom_range(19, 0) == 0, $urandom() & 32'h0000_0FFF);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
